// File: rtl/pixel_pair_streamer_pkg.sv
// Shared types for the pixel pair streamer: pixel/opcode widths and the stream FSM states.
package pixel_pair_streamer_pkg;

   localparam int pixelWidth  = 24;
   localparam int opCodeWidth = 4;

   typedef logic [pixelWidth-1:0]  pixel_t;
   typedef logic [opCodeWidth-1:0] opcode_t;

   typedef enum logic [2:0] {
      IDLE,
      RD_A,
      RD_B,
      CAP_B,
      SEND,
      DONE
   } streamState_t;

endpackage

// File: rtl/pixel_pair_streamer.sv
// Reads matching pixels from two images in frame memory and streams them as
// (pixelA, pixelB) pairs with the frame's opcode and user operand over valid/ready.
module pixel_pair_streamer
   import pixel_pair_streamer_pkg::*;
#(
   parameter int PIXEL_W = pixelWidth,
   parameter int OP_W    = opCodeWidth,
   parameter int ADDR_W  = 16,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [ADDR_W-1:0]  base_a,
   input  logic [ADDR_W-1:0]  base_b,
   input  logic [CNT_W-1:0]   pix_count,
   input  logic [OP_W-1:0]    opcode_in,
   input  logic [PIXEL_W-1:0] user_in,
   output logic               busy,
   output logic               done,
   output logic               mem_rd_en,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic [PIXEL_W-1:0] mem_rd_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PIXEL_W-1:0] out_pixel_a,
   output logic [PIXEL_W-1:0] out_pixel_b,
   output logic [OP_W-1:0]    out_opcode,
   output logic [PIXEL_W-1:0] out_user,
   output logic               out_last
);

   streamState_t      stateReg, stateNext;
   logic [CNT_W-1:0]  idxReg;
   logic [CNT_W-1:0]  countReg;
   logic [ADDR_W-1:0] baseAReg;
   logic [ADDR_W-1:0] baseBReg;
   logic [ADDR_W-1:0] idxAddr;
   logic              lastBeat;

   // Address sums are truncated to ADDR_W so image reads wrap around memory.
   assign idxAddr  = ADDR_W'(idxReg);
   assign lastBeat = (idxReg == countReg - CNT_W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         stateReg    <= IDLE;
         idxReg      <= '0;
         countReg    <= '0;
         baseAReg    <= '0;
         baseBReg    <= '0;
         out_pixel_a <= '0;
         out_pixel_b <= '0;
         out_opcode  <= '0;
         out_user    <= '0;
      end else begin
         stateReg <= stateNext;
         case (stateReg)
            IDLE: begin
               if (start) begin
                  baseAReg   <= base_a;
                  baseBReg   <= base_b;
                  countReg   <= pix_count;
                  out_opcode <= opcode_in;
                  out_user   <= user_in;
                  idxReg     <= '0;
               end
            end
            RD_B:  out_pixel_a <= mem_rd_data;
            CAP_B: out_pixel_b <= mem_rd_data;
            SEND: begin
               if (out_ready) begin
                  idxReg <= idxReg + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      stateNext = stateReg;
      busy      = (stateReg != IDLE);
      done      = 1'b0;
      mem_rd_en = 1'b0;
      mem_addr  = '0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      case (stateReg)
         IDLE: begin
            if (start) begin
               stateNext = (pix_count == '0) ? DONE : RD_A;
            end
         end
         RD_A: begin
            mem_rd_en = 1'b1;
            mem_addr  = baseAReg + idxAddr;
            stateNext = RD_B;
         end
         RD_B: begin
            mem_rd_en = 1'b1;
            mem_addr  = baseBReg + idxAddr;
            stateNext = CAP_B;
         end
         CAP_B: stateNext = SEND;
         SEND: begin
            // Pair registers are untouched here, so the beat holds until accepted.
            out_valid = 1'b1;
            out_last  = lastBeat;
            if (out_ready) begin
               stateNext = lastBeat ? DONE : RD_A;
            end
         end
         DONE: begin
            done      = 1'b1;
            stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

endmodule

// File: tb/tb_pixel_pair_streamer.sv
// Self-checking bench for pixel_pair_streamer: scoreboarded reads and beats plus
// per-scenario checks of latency, stalls, wrap-around, ignored starts and reset abort.
module tb_pixel_pair_streamer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] base_a, base_b;
   logic [15:0] pix_count;
   logic [3:0]  opcode_in;
   logic [23:0] user_in;
   logic        busy, done, mem_rd_en;
   logic [15:0] mem_addr;
   logic [23:0] mem_rd_data;
   logic        out_valid, out_ready, out_last;
   logic [23:0] out_pixel_a, out_pixel_b, out_user;
   logic [3:0]  out_opcode;

   typedef struct packed {
      logic [23:0] a;
      logic [23:0] b;
      logic [3:0]  op;
      logic [23:0] user;
      logic        last;
   } beat_t;

   beat_t       beatQ[$];
   logic [15:0] readQ[$];
   int          checks = 0;
   int          failures = 0;
   int          beatsSeen = 0;

   always #5 clk = ~clk;

   pixel_pair_streamer dut (
      .clk(clk), .rst(rst), .start(start), .base_a(base_a), .base_b(base_b),
      .pix_count(pix_count), .opcode_in(opcode_in), .user_in(user_in),
      .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
      .mem_rd_data(mem_rd_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_pixel_a(out_pixel_a), .out_pixel_b(out_pixel_b), .out_opcode(out_opcode),
      .out_user(out_user), .out_last(out_last)
   );

   function automatic logic [23:0] memVal(input logic [15:0] addr);
      return {addr[7:0] ^ 8'hC3, addr};
   endfunction

   // Frame memory: one-cycle read latency
   always @(posedge clk) begin
      if (mem_rd_en === 1'b1) mem_rd_data <= memVal(mem_addr);
   end

   // Scoreboard: consume any read or handshake happening at the coming edge, then advance.
   task automatic tick();
      beat_t       expB, gotB;
      logic [15:0] expAddr;
      if (mem_rd_en === 1'b1) begin
         checks++;
         if (readQ.size() == 0) begin
            failures++;
            $display("FAIL unexpected_read: got read at %h, required no read", mem_addr);
         end else begin
            expAddr = readQ.pop_front();
            if (mem_addr !== expAddr) begin
               failures++;
               $display("FAIL read_addr: got %h, required %h", mem_addr, expAddr);
            end
         end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         gotB.a = out_pixel_a; gotB.b = out_pixel_b; gotB.op = out_opcode;
         gotB.user = out_user; gotB.last = out_last;
         beatsSeen++;
         checks++;
         $display("beat a=%h b=%h op=%h user=%h last=%b", gotB.a, gotB.b, gotB.op, gotB.user, gotB.last);
         if (beatQ.size() == 0) begin
            failures++;
            $display("FAIL unexpected_beat: got a=%h b=%h, required no beat", gotB.a, gotB.b);
         end else begin
            expB = beatQ.pop_front();
            if (gotB !== expB) begin
               failures++;
               $display("FAIL beat: got a=%h b=%h op=%h user=%h last=%b, required a=%h b=%h op=%h user=%h last=%b",
                        gotB.a, gotB.b, gotB.op, gotB.user, gotB.last, expB.a, expB.b, expB.op, expB.user, expB.last);
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic pushExpect(input logic [15:0] ba, input logic [15:0] bb, input int n,
                             input logic [3:0] op, input logic [23:0] user);
      beat_t       e;
      logic [15:0] aa, bb2;
      for (int i = 0; i < n; i++) begin
         aa  = ba + 16'(i);
         bb2 = bb + 16'(i);
         readQ.push_back(aa);
         readQ.push_back(bb2);
         e.a = memVal(aa); e.b = memVal(bb2); e.op = op; e.user = user; e.last = (i == n - 1);
         beatQ.push_back(e);
      end
   endtask

   task automatic startXfer(input logic [15:0] ba, input logic [15:0] bb, input logic [15:0] n,
                            input logic [3:0] op, input logic [23:0] user);
      base_a = ba; base_b = bb; pix_count = n; opcode_in = op; user_in = user;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({busy, done, mem_rd_en, out_valid, out_last} !== 5'b0) begin
         failures++;
         $display("FAIL reset_flags: got %b, required 00000", {busy, done, mem_rd_en, out_valid, out_last});
      end
      checks++;
      if (mem_addr !== 16'h0) begin
         failures++;
         $display("FAIL reset_addr: got %h, required 0000", mem_addr);
      end
      checks++;
      if ({out_pixel_a, out_pixel_b, out_user, out_opcode} !== 76'h0) begin
         failures++;
         $display("FAIL reset_data: got %h %h %h %h, required zeros", out_pixel_a, out_pixel_b, out_user, out_opcode);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      bit doneSeen = 0;
      beatsSeen = 0;
      out_ready = 1'b1;
      pushExpect(16'h0100, 16'h0200, 3, 4'h5, 24'h123456);
      startXfer(16'h0100, 16'h0200, 16'd3, 4'h5, 24'h123456);
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b, required 1", busy); end
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid: got %b, required 0", out_valid); end
      tick();
      checks++;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_latency: got out_valid=%b 4 cycles after start, required 1", out_valid); end
      for (int i = 0; i < 40 && !doneSeen; i++) begin
         if (done === 1'b1) doneSeen = 1;
         else tick();
      end
      checks++;
      if (!doneSeen) begin failures++; $display("FAIL basic_done: got no done pulse, required one"); end
      checks++;
      if (beatsSeen != 3 || readQ.size() != 0 || beatQ.size() != 0) begin
         failures++;
         $display("FAIL basic_counts: got beats=%0d pendingReads=%0d pendingBeats=%0d, required 3 0 0",
                  beatsSeen, readQ.size(), beatQ.size());
      end
      // a start coinciding with the done cycle must be dropped
      base_a = 16'h0700; pix_count = 16'd1; start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if ({busy, done} !== 2'b00) begin failures++; $display("FAIL basic_after_done: got busy,done=%b, required 00", {busy, done}); end
   endtask

   task automatic test_stall();
      bit          doneSeen = 0;
      logic [76:0] snap;
      beatsSeen = 0;
      out_ready = 1'b0;
      pushExpect(16'h0300, 16'h0400, 2, 4'hA, 24'hABCDEF);
      startXfer(16'h0300, 16'h0400, 16'd2, 4'hA, 24'hABCDEF);
      for (int i = 0; i < 10 && out_valid !== 1'b1; i++) tick();
      checks++;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid: got %b, required 1", out_valid); end
      snap = {out_pixel_a, out_pixel_b, out_opcode, out_user, out_last};
      for (int k = 0; k < 5; k++) begin
         if (k == 1) begin
            base_a = 16'h0900; pix_count = 16'd7; opcode_in = 4'h3; user_in = 24'h777777; start = 1'b1;
         end
         tick();
         start = 1'b0;
         checks++;
         if (out_valid !== 1'b1 || mem_rd_en !== 1'b0 ||
             {out_pixel_a, out_pixel_b, out_opcode, out_user, out_last} !== snap) begin
            failures++;
            $display("FAIL stall_hold_%0d: got valid=%b rd=%b pair=%h, required valid=1 rd=0 pair=%h",
                     k, out_valid, mem_rd_en, {out_pixel_a, out_pixel_b, out_opcode, out_user, out_last}, snap);
         end
      end
      out_ready = 1'b1;
      for (int i = 0; i < 40 && !doneSeen; i++) begin
         if (done === 1'b1) doneSeen = 1;
         else tick();
      end
      checks++;
      if (!doneSeen || beatsSeen != 2 || readQ.size() != 0 || beatQ.size() != 0) begin
         failures++;
         $display("FAIL stall_complete: got done=%0d beats=%0d pendingReads=%0d, required 1 2 0",
                  doneSeen, beatsSeen, readQ.size());
      end
      tick();
   endtask

   task automatic test_zero();
      out_ready = 1'b1;
      startXfer(16'h0500, 16'h0600, 16'd0, 4'h1, 24'h000111);
      checks++;
      if ({done, busy, mem_rd_en, out_valid} !== 4'b1100) begin
         failures++;
         $display("FAIL zero_done: got done,busy,rd,valid=%b, required 1100", {done, busy, mem_rd_en, out_valid});
      end
      tick();
      checks++;
      if ({done, busy, mem_rd_en, out_valid} !== 4'b0000) begin
         failures++;
         $display("FAIL zero_idle: got done,busy,rd,valid=%b, required 0000", {done, busy, mem_rd_en, out_valid});
      end
      tick();
   endtask

   task automatic test_wrap();
      bit doneSeen = 0;
      beatsSeen = 0;
      out_ready = 1'b1;
      pushExpect(16'hFFFF, 16'h1000, 2, 4'hC, 24'h00BEEF);
      startXfer(16'hFFFF, 16'h1000, 16'd2, 4'hC, 24'h00BEEF);
      for (int i = 0; i < 40 && !doneSeen; i++) begin
         if (done === 1'b1) doneSeen = 1;
         else tick();
      end
      checks++;
      if (!doneSeen || beatsSeen != 2 || readQ.size() != 0 || beatQ.size() != 0) begin
         failures++;
         $display("FAIL wrap_complete: got done=%0d beats=%0d pendingReads=%0d, required 1 2 0",
                  doneSeen, beatsSeen, readQ.size());
      end
      tick();
   endtask

   task automatic test_reset_mid();
      bit sawActivity = 0;
      out_ready = 1'b0;
      pushExpect(16'h2000, 16'h3000, 3, 4'h9, 24'h456789);
      startXfer(16'h2000, 16'h3000, 16'd3, 4'h9, 24'h456789);
      for (int i = 0; i < 10 && out_valid !== 1'b1; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      readQ.delete();
      beatQ.delete();
      checks++;
      if ({out_valid, busy, done, out_pixel_a} !== 27'h0) begin
         failures++;
         $display("FAIL abort_state: got valid=%b busy=%b done=%b pixA=%h, required all 0",
                  out_valid, busy, done, out_pixel_a);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (done === 1'b1 || out_valid === 1'b1 || mem_rd_en === 1'b1) sawActivity = 1;
         tick();
      end
      checks++;
      if (sawActivity) begin failures++; $display("FAIL abort_quiet: got activity after reset, required none"); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion by 200us, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; start = 1'b0; out_ready = 1'b0;
      base_a = '0; base_b = '0; pix_count = '0; opcode_in = '0; user_in = '0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_stall();
      test_zero();
      test_wrap();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
